// File: rtl/ctr_seq_ctrl.sv
// Sequencer for counter_9bit: turns start/stop/clear requests into a clean
// clear pulse and an exact-length enable window with pause/resume.
module ctr_seq_ctrl #(
  parameter int unsigned CLR_CYCLES = 2,
  parameter bit          AUTO_CLR   = 1'b1
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear_req,
  input  logic [8:0] run_len,
  output logic       en_out,
  output logic       clr_out,
  output logic       busy,
  output logic       done,
  output logic [8:0] elapsed
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  localparam logic [3:0] CLR_LAST = 4'(CLR_CYCLES - 1);

  state_t     state;
  logic [8:0] len_q;
  logic [3:0] clr_cnt;
  logic       pend_run;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= S_IDLE;
      len_q    <= '0;
      clr_cnt  <= '0;
      pend_run <= 1'b0;
      elapsed  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clear_req) begin
            state    <= S_CLEAR;
            clr_cnt  <= '0;
            pend_run <= 1'b0;
          end else if (start) begin
            len_q   <= run_len;
            elapsed <= '0;
            if (AUTO_CLR) begin
              state    <= S_CLEAR;
              clr_cnt  <= '0;
              pend_run <= 1'b1;
            end else if (run_len == '0) begin
              state <= S_DONE;
            end else begin
              state <= S_RUN;
            end
          end
        end

        S_CLEAR: begin
          if (clear_req) begin
            clr_cnt  <= '0;
            pend_run <= 1'b0;
          end else if (clr_cnt == CLR_LAST) begin
            clr_cnt  <= '0;
            pend_run <= 1'b0;
            if (pend_run) begin
              state <= (len_q == '0) ? S_DONE : S_RUN;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            clr_cnt <= clr_cnt + 4'd1;
          end
        end

        S_RUN: begin
          if (clear_req) begin
            state    <= S_CLEAR;
            clr_cnt  <= '0;
            pend_run <= 1'b0;
            elapsed  <= '0;
          end else begin
            elapsed <= elapsed + 9'd1;
            if (stop) begin
              state <= S_PAUSE;
            end else if (elapsed == len_q - 9'd1) begin
              state <= S_DONE;
            end
          end
        end

        S_PAUSE: begin
          if (clear_req) begin
            state    <= S_CLEAR;
            clr_cnt  <= '0;
            pend_run <= 1'b0;
            elapsed  <= '0;
          end else if (start) begin
            // A stop on the terminal clock leaves the window already complete.
            state <= (elapsed == len_q) ? S_DONE : S_RUN;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign en_out  = (state == S_RUN);
  assign clr_out = (state == S_CLEAR);
  assign done    = (state == S_DONE);
  assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_ctr_seq_ctrl.sv
// Scoreboard bench for ctr_seq_ctrl: u0 without auto-clear, u1 with auto-clear,
// both fed the same requests; per-cycle expected traces are queued and popped.
module tb_ctr_seq_ctrl;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       start;
  logic       stop;
  logic       clear_req;
  logic [8:0] run_len;

  logic       en0, clr0, busy0, done0;
  logic [8:0] el0;
  logic       en1, clr1, busy1, done1;
  logic [8:0] el1;

  int unsigned checks = 0;
  int unsigned passed = 0;

  logic [12:0] sb[$];
  logic [12:0] got;
  logic [12:0] exp_v;

  always #5 clk = ~clk;

  ctr_seq_ctrl #(.CLR_CYCLES(2), .AUTO_CLR(1'b0)) u0 (
    .clk(clk), .clr_n(clr_n), .start(start), .stop(stop), .clear_req(clear_req),
    .run_len(run_len), .en_out(en0), .clr_out(clr0), .busy(busy0), .done(done0),
    .elapsed(el0)
  );

  ctr_seq_ctrl #(.CLR_CYCLES(2), .AUTO_CLR(1'b1)) u1 (
    .clk(clk), .clr_n(clr_n), .start(start), .stop(stop), .clear_req(clear_req),
    .run_len(run_len), .en_out(en1), .clr_out(clr1), .busy(busy1), .done(done1),
    .elapsed(el1)
  );

  // Packs {en_out, clr_out, done, busy, elapsed}.
  function automatic logic [12:0] pk(input logic e, input logic c, input logic d,
                                     input logic b, input logic [8:0] el);
    return {e, c, d, b, el};
  endfunction

  task automatic wait_idle();
    int unsigned n = 0;
    start = 1'b0; stop = 1'b0; clear_req = 1'b0;
    while ((busy0 || busy1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy0 || busy1) $display("FAIL wait_idle busy0=%b busy1=%b required 0 0", busy0, busy1);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clr_n = 1'b0; start = 1'b0; stop = 1'b0; clear_req = 1'b0; run_len = 9'd0;
    #12;
    got = pk(en0, clr0, done0, busy0, el0);
    checks++;
    if (got !== 13'd0) $display("FAIL reset_u0 got=%b required=%b", got, 13'd0); else passed++;
    got = pk(en1, clr1, done1, busy1, el1);
    checks++;
    if (got !== 13'd0) $display("FAIL reset_u1 got=%b required=%b", got, 13'd0); else passed++;
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    got = pk(en0, clr0, done0, busy0, el0);
    checks++;
    if (got !== 13'd0) $display("FAIL reset_release got=%b required=%b", got, 13'd0); else passed++;
  endtask

  // start+stop together in IDLE, run_len changed after latch
  task automatic test_basic_run();
    sb.delete();
    for (int i = 0; i < 5; i++) sb.push_back(pk(1'b1, 1'b0, 1'b0, 1'b1, 9'(i)));
    sb.push_back(pk(1'b0, 1'b0, 1'b1, 1'b1, 9'd5));
    sb.push_back(pk(1'b0, 1'b0, 1'b0, 1'b0, 9'd5));
    start = 1'b1; stop = 1'b1; run_len = 9'd5;
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk);
      start = 1'b0; stop = 1'b0; run_len = 9'd2;
      got = pk(en0, clr0, done0, busy0, el0);
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) $display("FAIL basic_run cyc %0d got=%b required=%b", i, got, exp_v);
      else passed++;
    end
  endtask

  task automatic test_auto_clear();
    sb.delete();
    for (int i = 0; i < 2; i++) sb.push_back(pk(1'b0, 1'b1, 1'b0, 1'b1, 9'd0));
    for (int i = 0; i < 3; i++) sb.push_back(pk(1'b1, 1'b0, 1'b0, 1'b1, 9'(i)));
    sb.push_back(pk(1'b0, 1'b0, 1'b1, 1'b1, 9'd3));
    sb.push_back(pk(1'b0, 1'b0, 1'b0, 1'b0, 9'd3));
    start = 1'b1; run_len = 9'd3;
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk);
      start = 1'b0;
      got = pk(en1, clr1, done1, busy1, el1);
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) $display("FAIL auto_clear cyc %0d got=%b required=%b", i, got, exp_v);
      else passed++;
    end
  endtask

  // stop held through PAUSE (ignored), then start+stop together resumes
  task automatic test_pause_resume();
    sb.delete();
    for (int i = 0; i < 3; i++) sb.push_back(pk(1'b1, 1'b0, 1'b0, 1'b1, 9'(i)));
    for (int i = 0; i < 4; i++) sb.push_back(pk(1'b0, 1'b0, 1'b0, 1'b1, 9'd3));
    for (int i = 3; i < 8; i++) sb.push_back(pk(1'b1, 1'b0, 1'b0, 1'b1, 9'(i)));
    sb.push_back(pk(1'b0, 1'b0, 1'b1, 1'b1, 9'd8));
    sb.push_back(pk(1'b0, 1'b0, 1'b0, 1'b0, 9'd8));
    start = 1'b1; run_len = 9'd8;
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk);
      got = pk(en0, clr0, done0, busy0, el0);
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) $display("FAIL pause_resume cyc %0d got=%b required=%b", i, got, exp_v);
      else passed++;
      stop  = (i >= 2 && i <= 6);
      start = (i == 6);
    end
  endtask

  // start held into DONE must not retrigger
  task automatic test_zero_len();
    sb.delete();
    sb.push_back(pk(1'b0, 1'b0, 1'b1, 1'b1, 9'd0));
    sb.push_back(pk(1'b0, 1'b0, 1'b0, 1'b0, 9'd0));
    sb.push_back(pk(1'b0, 1'b0, 1'b0, 1'b0, 9'd0));
    start = 1'b1; run_len = 9'd0;
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk);
      got = pk(en0, clr0, done0, busy0, el0);
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) $display("FAIL zero_len cyc %0d got=%b required=%b", i, got, exp_v);
      else passed++;
      start = 1'b0;
    end
  endtask

  task automatic test_max_len();
    sb.delete();
    for (int i = 0; i < 511; i++) sb.push_back(pk(1'b1, 1'b0, 1'b0, 1'b1, 9'(i)));
    sb.push_back(pk(1'b0, 1'b0, 1'b1, 1'b1, 9'd511));
    sb.push_back(pk(1'b0, 1'b0, 1'b0, 1'b0, 9'd511));
    start = 1'b1; run_len = 9'd511;
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk);
      start = 1'b0;
      got = pk(en0, clr0, done0, busy0, el0);
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) $display("FAIL max_len cyc %0d got=%b required=%b", i, got, exp_v);
      else passed++;
    end
  endtask

  task automatic test_clear_stop();
    sb.delete();
    for (int i = 0; i < 5; i++) sb.push_back(pk(1'b1, 1'b0, 1'b0, 1'b1, 9'(i)));
    for (int i = 0; i < 2; i++) sb.push_back(pk(1'b0, 1'b1, 1'b0, 1'b1, 9'd0));
    for (int i = 0; i < 2; i++) sb.push_back(pk(1'b0, 1'b0, 1'b0, 1'b0, 9'd0));
    start = 1'b1; run_len = 9'd8;
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk);
      got = pk(en0, clr0, done0, busy0, el0);
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) $display("FAIL clear_stop cyc %0d got=%b required=%b", i, got, exp_v);
      else passed++;
      start     = 1'b0;
      clear_req = (i == 4);
      stop      = (i == 4);
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1; run_len = 9'd20;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    got = pk(en0, clr0, done0, busy0, el0);
    checks++;
    if (got !== pk(1'b1, 1'b0, 1'b0, 1'b1, 9'd1))
      $display("FAIL arst_pre_u0 got=%b required=%b", got, pk(1'b1, 1'b0, 1'b0, 1'b1, 9'd1));
    else passed++;
    got = pk(en1, clr1, done1, busy1, el1);
    checks++;
    if (got !== pk(1'b0, 1'b1, 1'b0, 1'b1, 9'd0))
      $display("FAIL arst_pre_u1 got=%b required=%b", got, pk(1'b0, 1'b1, 1'b0, 1'b1, 9'd0));
    else passed++;
    #2 clr_n = 1'b0;
    #1;
    got = pk(en0, clr0, done0, busy0, el0);
    checks++;
    if (got !== 13'd0) $display("FAIL arst_run_u0 got=%b required=%b", got, 13'd0); else passed++;
    got = pk(en1, clr1, done1, busy1, el1);
    checks++;
    if (got !== 13'd0) $display("FAIL arst_clear_u1 got=%b required=%b", got, 13'd0); else passed++;
    @(negedge clk);
    clr_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = pk(en0, clr0, done0, busy0, el0);
      checks++;
      if (got !== 13'd0) $display("FAIL arst_idle cyc %0d got=%b required=%b", i, got, 13'd0);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    wait_idle();
    test_auto_clear();
    wait_idle();
    test_pause_resume();
    wait_idle();
    test_zero_len();
    wait_idle();
    test_max_len();
    wait_idle();
    test_clear_stop();
    wait_idle();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
